// File: rtl/result_select_arbiter.sv
// Round-robin arbiter over four result lanes feeding a single-entry output register.
// out_tag is registered alongside out_data so the downstream mux select tracks the data.
module result_select_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_tag,
  output logic [7:0]       xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       rr_ptr_reg, rr_ptr_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [1:0]       tag_reg, tag_next;
  logic [7:0]       cnt_reg, cnt_next;

  logic [WIDTH-1:0] lane_data [4];
  logic [3:0]       rot_valid;
  logic [1:0]       grant_offs;
  logic [1:0]       grant_lane;
  logic             grant_found;
  logic             can_load;
  logic             load;

  assign lane_data[0] = in0;
  assign lane_data[1] = in1;
  assign lane_data[2] = in2;
  assign lane_data[3] = in3;

  // rot_valid[k] is the valid of the lane k steps after the priority pointer
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_valid[gi] = in_valid[rr_ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_offs  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_found = 1'b1;
        grant_offs  = 2'(k);
      end
    end
  end

  assign grant_lane = rr_ptr_reg + grant_offs;
  assign can_load   = (state_reg == EMPTY) || out_ready;
  assign load       = can_load && grant_found;

  // rst_n gating keeps every lane stalled while reset is held
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rdy
      assign in_ready[gi] = rst_n && load && (grant_lane == 2'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    data_next   = data_reg;
    tag_next    = tag_reg;
    cnt_next    = cnt_reg + 8'((state_reg == FULL) && out_ready);
    if (load) begin
      state_next  = FULL;
      data_next   = lane_data[grant_lane];
      tag_next    = grant_lane;
      rr_ptr_next = grant_lane + 2'd1;
    end else if (can_load) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= EMPTY;
      rr_ptr_reg <= 2'd0;
      data_reg   <= '0;
      tag_reg    <= 2'd0;
      cnt_reg    <= 8'd0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      data_reg   <= data_next;
      tag_reg    <= tag_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_tag   = tag_reg;
  assign xfer_cnt  = cnt_reg;

endmodule

// File: tb/tb_result_select_arbiter.sv
// Scoreboard bench for result_select_arbiter: directed test-plan scenarios, then random traffic.
module tb_result_select_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] in_valid = 4'd0;
  logic [3:0] in_ready;
  logic [7:0] in0 = 8'd0, in1 = 8'd0, in2 = 8'd0, in3 = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_tag;
  logic [7:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_select_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .xfer_cnt(xfer_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] tag;
  } exp_t;

  exp_t sb[$];

  // reference model state
  bit       m_full = 0;
  int       m_ptr  = 0;
  int       m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane_val(input int i);
    case (i)
      0: return in0;
      1: return in1;
      2: return in2;
      default: return in3;
    endcase
  endfunction

  // monitor: every output handshake consumes the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: handshake with no expected value, data %0h tag %0d", out_data, out_tag);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
      end
    end
  end

  // one clock cycle: inputs applied just after posedge, checked mid-cycle and after the edge
  task automatic step(input logic [3:0] v, input logic r);
    int         g;
    bit         found;
    bit         can_load;
    logic [3:0] exp_rdy;
    in_valid  = v;
    out_ready = r;
    @(negedge clk);
    found = 0;
    g = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && v[(m_ptr + k) % 4]) begin
        found = 1;
        g = (m_ptr + k) % 4;
      end
    end
    can_load = !m_full || r;
    exp_rdy = 4'd0;
    if (can_load && found) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (m_full && r) m_cnt = (m_cnt + 1) % 256;
    if (can_load && found) begin
      sb.push_back('{data: lane_val(g), tag: 2'(g)});
      m_ptr  = (g + 1) % 4;
      m_full = 1;
    end else if (can_load) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  // asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 4'hF;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'd0;
    sb.delete();
    m_full = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rr_d [4];
    logic [3:0] rv;
    logic       rr;
    rr_d[0] = 8'hFF; rr_d[1] = 8'h00; rr_d[2] = 8'h01; rr_d[3] = 8'hFE;
    #1;

    // single lane
    do_reset();
    in0 = 8'hFF;
    step(4'b0001, 1'b1);
    chk("single_data", 32'(out_data), 32'hFF);
    chk("single_tag", 32'(out_tag), 32'd0);
    step(4'b0000, 1'b1);
    chk("single_cnt", 32'(xfer_cnt), 32'd1);

    // round robin
    do_reset();
    in0 = rr_d[0]; in1 = rr_d[1]; in2 = rr_d[2]; in3 = rr_d[3];
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      chk("rr_tag", 32'(out_tag), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'(rr_d[i % 4]));
    end
    step(4'b0000, 1'b1);

    // backpressure, then drain
    do_reset();
    step(4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 1'b0);
      chk("bp_data", 32'(out_data), 32'h01);
      chk("bp_tag", 32'(out_tag), 32'd2);
    end
    step(4'b1000, 1'b1);
    chk("bp_release_data", 32'(out_data), 32'hFE);
    step(4'b0000, 1'b1);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // pointer wrap after lane 3
    step(4'b0101, 1'b1);
    chk("wrap_tag", 32'(out_tag), 32'd0);

    // reset while FULL, then 256 transfers wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      in0 = 8'($urandom);
      step(4'b0001, 1'b1);
    end
    step(4'b0000, 1'b1);
    chk("cnt_wrap", 32'(xfer_cnt), 32'd0);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      in0 = 8'($urandom); in1 = 8'($urandom);
      in2 = 8'($urandom); in3 = 8'($urandom);
      rv = 4'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(rv, rr);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
